i2s_rx_deserializer: RTL

Receive-side front end of the I2S slave IP in the AL4S3B fabric.
- Oversamples the external I2S_CLK_i, I2S_WS_CLK_i and I2S_DIN_i pins on WB_CLK.
- Recovers Philips-format serial audio words.
- Hands each left/right word, channel-tagged, to the downstream sample FIFO/DMA stage through a valid/ready handshake.
- Sits between the top-level I2S pins and the FIFO that drives SDMA_Req_I2S and the I2S RX interrupt.

---
 rtl/i2s_rx_pkg.sv | 9 +
 rtl/i2s_rx_sync.sv | 14 +
 rtl/i2s_rx_deserializer.sv | 82 ++++++++
 3 files changed

// File: rtl/i2s_rx_pkg.sv
// i2s_rx_pkg: shared state type, channel codes and counter sizing for the I2S receiver
package i2s_rx_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, SHIFT = 2'd2} state_t;
  localparam logic CHAN_LEFT = 1'b0;
  localparam logic CHAN_RIGHT = 1'b1;
  function automatic int cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction
endpackage

// File: rtl/i2s_rx_sync.sv
// i2s_rx_sync: two-flop synchronizer with a history flop for rising-edge detection
module i2s_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic s,
  output logic rise
);
  logic m, h;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {m, s, h} <= '0;
    else {m, s, h} <= {d, m, s};
  assign rise = s & ~h;
endmodule

// File: rtl/i2s_rx_deserializer.sv
// i2s_rx_deserializer: oversampled Philips I2S receiver with a single-entry valid/ready output
// Define I2S_RX_DEBUG_EN to build the registered rx_debug_o bus; otherwise it is tied to zero.
module i2s_rx_deserializer
  import i2s_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  WB_CLK,
  input  logic                  WB_RST_n,
  input  logic                  I2S_CLK_i,
  input  logic                  I2S_WS_CLK_i,
  input  logic                  I2S_DIN_i,
  input  logic                  rx_en_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_chan_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  rx_ovf_o,
  input  logic                  ovf_clr_i,
  output logic [7:0]            rx_debug_o
);
  localparam int CW = cnt_width(DATA_WIDTH);
  state_t state, state_nxt;
  logic sck_s, sck_rise, ws_s, ws_rise, din_s, din_rise, unused_sync;
  logic ws_last, ws_edge, take, fin, load, ovf_set;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt, word;
  logic [CW-1:0] bit_cnt, cnt_nxt;
  i2s_rx_sync u_sck (.clk(WB_CLK), .rst_n(WB_RST_n), .d(I2S_CLK_i), .s(sck_s), .rise(sck_rise));
  i2s_rx_sync u_ws (.clk(WB_CLK), .rst_n(WB_RST_n), .d(I2S_WS_CLK_i), .s(ws_s), .rise(ws_rise));
  i2s_rx_sync u_din (.clk(WB_CLK), .rst_n(WB_RST_n), .d(I2S_DIN_i), .s(din_s), .rise(din_rise));
  assign unused_sync = ws_rise ^ din_rise ^ sck_s;
  assign ws_edge = sck_rise & (ws_s != ws_last);
  always_ff @(posedge WB_CLK or negedge WB_RST_n)
    if (!WB_RST_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = !rx_en_i ? IDLE :
                (state == IDLE) ? SYNC :
                (state == SYNC && ws_edge) ? SHIFT : state;
  // The WS-change rise still carries the old word's LSB, so it is shifted before finalizing.
  always_comb begin
    take = sck_rise && state == SHIFT && bit_cnt < CW'(DATA_WIDTH);
    shreg_nxt = take ? {shreg[DATA_WIDTH-2:0], din_s} : shreg;
    cnt_nxt = take ? bit_cnt + 1'b1 : bit_cnt;
    fin = ws_edge && state == SHIFT && rx_en_i && cnt_nxt != '0;
    word = shreg_nxt << (CW'(DATA_WIDTH) - cnt_nxt);
  end
  // ws_last follows WS while idle so edges seen before enabling never count.
  always_ff @(posedge WB_CLK or negedge WB_RST_n)
    if (!WB_RST_n) begin
      shreg <= '0;
      bit_cnt <= '0;
      ws_last <= 1'b0;
    end else begin
      shreg <= (state == SHIFT && !ws_edge) ? shreg_nxt : '0;
      bit_cnt <= (state == SHIFT && !ws_edge) ? cnt_nxt : '0;
      ws_last <= (state == IDLE || sck_rise) ? ws_s : ws_last;
    end
  assign load = fin & (~rx_valid_o | rx_ready_i);
  assign ovf_set = fin & rx_valid_o & ~rx_ready_i;
  always_ff @(posedge WB_CLK or negedge WB_RST_n)
    if (!WB_RST_n) begin
      rx_data_o <= '0;
      rx_chan_o <= CHAN_LEFT;
      rx_valid_o <= 1'b0;
      rx_ovf_o <= 1'b0;
    end else begin
      rx_valid_o <= load | (rx_valid_o & ~rx_ready_i);
      rx_ovf_o <= ovf_set | (rx_ovf_o & ~ovf_clr_i);
      if (load) begin
        rx_data_o <= word;
        rx_chan_o <= ws_last;
      end
    end
`ifdef I2S_RX_DEBUG_EN
  always_ff @(posedge WB_CLK or negedge WB_RST_n)
    if (!WB_RST_n) rx_debug_o <= '0;
    else rx_debug_o <= {state, ws_s, sck_s, din_s, rx_ovf_o, bit_cnt[1:0]};
`else
  assign rx_debug_o = 8'h00;
`endif
endmodule
